// File: rtl/pipeline_hazard_ctrl_if.sv
// Port bundle between the pipeline registers and the hazard controller.
// The stall/flush/wait counter signals exist only when HAZ_PERF_EN is defined.
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       ex_memread;
  logic [4:0] ex_rd;
  logic       mem_branch;
  logic       mem_zero;
  logic       mem_memread;
  logic       mem_memwrite;
  logic       dmem_ready;

  logic       pc_write;
  logic       pc_sel_br;
  logic       ifid_write;
  logic       ifid_flush;
  logic       idex_flush;
  logic       exmem_flush;
  logic       exmem_hold;
  logic       dmem_req;
  logic       mem_err;
`ifdef HAZ_PERF_EN
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic [CNT_W-1:0] wait_cnt;
`endif

  modport master (
    output id_rs1, id_rs2, ex_memread, ex_rd, mem_branch, mem_zero,
           mem_memread, mem_memwrite, dmem_ready,
`ifdef HAZ_PERF_EN
    input  stall_cnt, flush_cnt, wait_cnt,
`endif
    input  pc_write, pc_sel_br, ifid_write, ifid_flush, idex_flush,
           exmem_flush, exmem_hold, dmem_req, mem_err
  );

  modport slave (
    input  id_rs1, id_rs2, ex_memread, ex_rd, mem_branch, mem_zero,
           mem_memread, mem_memwrite, dmem_ready,
`ifdef HAZ_PERF_EN
    output stall_cnt, flush_cnt, wait_cnt,
`endif
    output pc_write, pc_sel_br, ifid_write, ifid_flush, idex_flush,
           exmem_flush, exmem_hold, dmem_req, mem_err
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for the 5-stage RV64 pipeline: load-use bubbles, MEM-stage branch
// flushes and data-memory freezes with timeout. Define HAZ_PERF_EN for performance counters.
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input logic                   clk,
  input logic                   reset,
  pipeline_hazard_ctrl_if.slave hz
);

  localparam int CTR_W = $clog2(MEM_TIMEOUT) + 1;
  localparam logic [CTR_W-1:0] TIMEOUT_LAST = CTR_W'(MEM_TIMEOUT - 1);

  typedef enum logic {RUN, MEM_WAIT} state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic [CTR_W-1:0] r_waitCtr;
  logic [CTR_W-1:0] w_nextWaitCtr;
  logic             r_memErr;
  logic             w_setErr;

  logic w_memAcc;
  logic w_brTaken;
  logic w_loadUse;
  logic w_memPending;
  logic w_timeout;
  logic w_freeze;
  logic w_stallEvt;
  logic w_flushEvt;

  logic w_pcWrite;
  logic w_pcSelBr;
  logic w_ifidWrite;
  logic w_ifidFlush;
  logic w_idexFlush;
  logic w_exmemFlush;
  logic w_exmemHold;
  logic w_dmemReq;

  assign w_memAcc     = hz.mem_memread | hz.mem_memwrite;
  assign w_brTaken    = hz.mem_branch & hz.mem_zero;
  assign w_loadUse    = hz.ex_memread & (hz.ex_rd != 5'd0) &
                        ((hz.ex_rd == hz.id_rs1) | (hz.ex_rd == hz.id_rs2));
  // wait_ctr counts cycles the current access has been outstanding; the cycle that
  // reaches MEM_TIMEOUT abandons the access instead of freezing again.
  assign w_memPending = w_memAcc & ~hz.dmem_ready;
  assign w_timeout    = w_memPending & (r_waitCtr == TIMEOUT_LAST);
  assign w_freeze     = w_memPending & ~w_timeout;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= RUN;
      r_waitCtr <= '0;
      r_memErr  <= 1'b0;
    end else begin
      r_state   <= w_nextState;
      r_waitCtr <= w_nextWaitCtr;
      if (w_setErr) r_memErr <= 1'b1;
    end
  end

  always_comb begin
    w_nextState   = r_state;
    w_nextWaitCtr = '0;
    w_setErr      = 1'b0;
    w_stallEvt    = 1'b0;
    w_flushEvt    = 1'b0;
    w_pcWrite     = 1'b1;
    w_pcSelBr     = 1'b0;
    w_ifidWrite   = 1'b1;
    w_ifidFlush   = 1'b0;
    w_idexFlush   = 1'b0;
    w_exmemFlush  = 1'b0;
    w_exmemHold   = 1'b0;
    w_dmemReq     = w_memAcc;

    case (r_state)
      RUN:      if (w_freeze) w_nextState = MEM_WAIT;
      MEM_WAIT: w_nextState = w_freeze ? MEM_WAIT : RUN;
      default:  w_nextState = RUN;
    endcase

    if (w_freeze) begin
      w_nextWaitCtr = r_waitCtr + CTR_W'(1);
      w_pcWrite     = 1'b0;
      w_ifidWrite   = 1'b0;
      w_exmemHold   = 1'b1;
    end else begin
      if (w_timeout) begin
        w_exmemFlush = 1'b1;
        w_setErr     = 1'b1;
      end
      // A taken branch squashes the load-use victim, so its bubble is not needed.
      if (w_brTaken) begin
        w_pcSelBr    = 1'b1;
        w_ifidFlush  = 1'b1;
        w_idexFlush  = 1'b1;
        w_exmemFlush = 1'b1;
        w_flushEvt   = 1'b1;
      end else if (w_loadUse) begin
        w_pcWrite   = 1'b0;
        w_ifidWrite = 1'b0;
        w_idexFlush = 1'b1;
        w_stallEvt  = 1'b1;
      end
    end

    if (reset) begin
      w_pcWrite    = 1'b0;
      w_pcSelBr    = 1'b0;
      w_ifidWrite  = 1'b0;
      w_ifidFlush  = 1'b0;
      w_idexFlush  = 1'b0;
      w_exmemFlush = 1'b0;
      w_exmemHold  = 1'b0;
      w_dmemReq    = 1'b0;
    end
  end

  assign hz.pc_write    = w_pcWrite;
  assign hz.pc_sel_br   = w_pcSelBr;
  assign hz.ifid_write  = w_ifidWrite;
  assign hz.ifid_flush  = w_ifidFlush;
  assign hz.idex_flush  = w_idexFlush;
  assign hz.exmem_flush = w_exmemFlush;
  assign hz.exmem_hold  = w_exmemHold;
  assign hz.dmem_req    = w_dmemReq;
  assign hz.mem_err     = r_memErr;

`ifdef HAZ_PERF_EN
  logic [CNT_W-1:0] r_stallCnt;
  logic [CNT_W-1:0] r_flushCnt;
  logic [CNT_W-1:0] r_waitCnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stallCnt <= '0;
      r_flushCnt <= '0;
      r_waitCnt  <= '0;
    end else begin
      if (w_stallEvt) r_stallCnt <= r_stallCnt + CNT_W'(1);
      if (w_flushEvt) r_flushCnt <= r_flushCnt + CNT_W'(1);
      if (w_freeze)   r_waitCnt  <= r_waitCnt + CNT_W'(1);
    end
  end

  assign hz.stall_cnt = r_stallCnt;
  assign hz.flush_cnt = r_flushCnt;
  assign hz.wait_cnt  = r_waitCnt;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: expected control vectors are queued as each
// cycle's inputs are driven and popped when the outputs are sampled mid-cycle.
module tb_pipeline_hazard_ctrl;

  localparam int MEM_TIMEOUT = 4;
  localparam int CNT_W       = 8;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       exMemread;
    logic [4:0] exRd;
    logic       memBranch;
    logic       memZero;
    logic       memMemread;
    logic       memMemwrite;
    logic       dmemReady;
  } stim_t;

  // {pc_write, pc_sel_br, ifid_write, ifid_flush, idex_flush, exmem_flush, exmem_hold, dmem_req, mem_err}
  localparam logic [8:0] EXP_NORMAL  = 9'b101000000;
  localparam logic [8:0] EXP_BUBBLE  = 9'b000010000;
  localparam logic [8:0] EXP_BRANCH  = 9'b111111000;
  localparam logic [8:0] EXP_FREEZE  = 9'b000000110;
  localparam logic [8:0] EXP_ADVMEM  = 9'b101000010;
  localparam logic [8:0] EXP_TIMEOUT = 9'b101001010;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();

  pipeline_hazard_ctrl #(
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .CNT_W      (CNT_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .hz   (hz)
  );

  always #5 clk = ~clk;

  logic [8:0] expQ[$];
  int testsRun    = 0;
  int testsFailed = 0;
  int expStall    = 0;
  int expFlush    = 0;
  int expWait     = 0;

  wire [8:0] outVec = {hz.pc_write, hz.pc_sel_br, hz.ifid_write, hz.ifid_flush, hz.idex_flush,
                       hz.exmem_flush, hz.exmem_hold, hz.dmem_req, hz.mem_err};

  function automatic stim_t mk(input logic [4:0] rs1, input logic [4:0] rs2, input logic exMr,
                               input logic [4:0] exRd, input logic br, input logic zero,
                               input logic mr, input logic mw, input logic rdy);
    stim_t s;
    s.rs1 = rs1; s.rs2 = rs2; s.exMemread = exMr; s.exRd = exRd;
    s.memBranch = br; s.memZero = zero; s.memMemread = mr; s.memMemwrite = mw; s.dmemReady = rdy;
    return s;
  endfunction

  task automatic applyStimulus(input stim_t s, input logic [8:0] e);
    hz.id_rs1       = s.rs1;
    hz.id_rs2       = s.rs2;
    hz.ex_memread   = s.exMemread;
    hz.ex_rd        = s.exRd;
    hz.mem_branch   = s.memBranch;
    hz.mem_zero     = s.memZero;
    hz.mem_memread  = s.memMemread;
    hz.mem_memwrite = s.memMemwrite;
    hz.dmem_ready   = s.dmemReady;
    expQ.push_back(e);
    if (e[4] & ~e[8]) expStall++;
    if (e[7]) expFlush++;
    if (e[2]) expWait++;
  endtask

  task automatic test_reset();
    logic [8:0] e;
    applyStimulus(mk(5'd31, 5'd31, 1'b1, 5'd31, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1), 9'b0);
    expStall = 0; expFlush = 0; expWait = 0;
    #2;
    e = expQ.pop_front();
    testsRun++;
    if (outVec !== e) begin
      testsFailed++;
      $display("[TB] FAIL reset_held: got %b want %b", outVec, e);
    end
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), EXP_NORMAL);
    #2;
    e = expQ.pop_front();
    testsRun++;
    if (outVec !== e) begin
      testsFailed++;
      $display("[TB] FAIL reset_release: got %b want %b", outVec, e);
    end
  endtask

  task automatic test_load_use();
    stim_t st[5];
    logic [8:0] ex[5];
    logic [8:0] e;
    st[0] = mk(5'd0, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); ex[0] = EXP_BUBBLE;
    st[1] = mk(5'd0, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); ex[1] = EXP_NORMAL;
    st[2] = mk(5'd7, 5'd2, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); ex[2] = EXP_BUBBLE;
    st[3] = mk(5'd7, 5'd7, 1'b0, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); ex[3] = EXP_NORMAL;
    st[4] = mk(5'd9, 5'd9, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); ex[4] = EXP_BUBBLE;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      applyStimulus(st[i], ex[i]);
      #2;
      e = expQ.pop_front();
      testsRun++;
      if (outVec !== e) begin
        testsFailed++;
        $display("[TB] FAIL load_use step %0d: got %b want %b", i, outVec, e);
      end
    end
  endtask

  task automatic test_branch();
    stim_t st[4];
    logic [8:0] ex[4];
    logic [8:0] e;
    st[0] = mk(5'd4, 5'd5, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); ex[0] = EXP_BRANCH;
    st[1] = mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); ex[1] = EXP_NORMAL;
    st[2] = mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1); ex[2] = EXP_BRANCH;
    st[3] = mk(5'd3, 5'd3, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); ex[3] = EXP_BUBBLE;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      applyStimulus(st[i], ex[i]);
      #2;
      e = expQ.pop_front();
      testsRun++;
      if (outVec !== e) begin
        testsFailed++;
        $display("[TB] FAIL branch step %0d: got %b want %b", i, outVec, e);
      end
    end
  endtask

  task automatic test_mem_wait();
    stim_t st[8];
    logic [8:0] ex[8];
    logic [8:0] e;
    for (int i = 0; i < 3; i++) begin
      st[i] = mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); ex[i] = EXP_FREEZE;
    end
    st[3] = mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1); ex[3] = EXP_ADVMEM;
    st[4] = mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1); ex[4] = EXP_ADVMEM;
    st[5] = mk(5'd6, 5'd0, 1'b1, 5'd6, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0); ex[5] = EXP_FREEZE;
    st[6] = mk(5'd6, 5'd0, 1'b1, 5'd6, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1); ex[6] = 9'b000010010;
    st[7] = mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); ex[7] = EXP_NORMAL;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      applyStimulus(st[i], ex[i]);
      #2;
      e = expQ.pop_front();
      testsRun++;
      if (outVec !== e) begin
        testsFailed++;
        $display("[TB] FAIL mem_wait step %0d: got %b want %b", i, outVec, e);
      end
    end
`ifdef HAZ_PERF_EN
    #4;
    testsRun++;
    if ({hz.stall_cnt, hz.flush_cnt, hz.wait_cnt} !== {CNT_W'(expStall), CNT_W'(expFlush), CNT_W'(expWait)}) begin
      testsFailed++;
      $display("[TB] FAIL perf_counters: got stall %0d flush %0d wait %0d want %0d %0d %0d",
               hz.stall_cnt, hz.flush_cnt, hz.wait_cnt, expStall, expFlush, expWait);
    end
`endif
  endtask

  task automatic test_timeout();
    stim_t st[7];
    logic [8:0] ex[7];
    logic [8:0] e;
    for (int i = 0; i < 3; i++) begin
      st[i] = mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); ex[i] = EXP_FREEZE;
    end
    st[3] = mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); ex[3] = EXP_TIMEOUT;
    st[4] = mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); ex[4] = EXP_NORMAL | 9'b1;
    st[5] = mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); ex[5] = EXP_NORMAL | 9'b1;
    st[6] = mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1); ex[6] = EXP_ADVMEM | 9'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      applyStimulus(st[i], ex[i]);
      #2;
      e = expQ.pop_front();
      testsRun++;
      if (outVec !== e) begin
        testsFailed++;
        $display("[TB] FAIL timeout step %0d: got %b want %b", i, outVec, e);
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    stim_t st[6];
    logic [8:0] ex[6];
    logic [8:0] e;
    stim_t waitStim;
    waitStim = mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      applyStimulus(waitStim, EXP_FREEZE | 9'b1);
      #2;
      e = expQ.pop_front();
      testsRun++;
      if (outVec !== e) begin
        testsFailed++;
        $display("[TB] FAIL pre_reset_wait step %0d: got %b want %b", i, outVec, e);
      end
    end
    reset = 1'b1;
    expStall = 0; expFlush = 0; expWait = 0;
    #1;
    testsRun++;
    if (outVec !== 9'b0) begin
      testsFailed++;
      $display("[TB] FAIL async_reset_outputs: got %b want %b", outVec, 9'b0);
    end
`ifdef HAZ_PERF_EN
    testsRun++;
    if ({hz.stall_cnt, hz.flush_cnt, hz.wait_cnt} !== '0) begin
      testsFailed++;
      $display("[TB] FAIL reset_counters: got stall %0d flush %0d wait %0d want 0 0 0",
               hz.stall_cnt, hz.flush_cnt, hz.wait_cnt);
    end
`endif
    st[0] = mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); ex[0] = EXP_NORMAL;
    for (int i = 1; i < 4; i++) begin
      st[i] = waitStim; ex[i] = EXP_FREEZE;
    end
    st[4] = waitStim; ex[4] = EXP_TIMEOUT;
    st[5] = st[0];    ex[5] = EXP_NORMAL | 9'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 0) reset = 1'b0;
      applyStimulus(st[i], ex[i]);
      #2;
      e = expQ.pop_front();
      testsRun++;
      if (outVec !== e) begin
        testsFailed++;
        $display("[TB] FAIL post_reset step %0d: got %b want %b", i, outVec, e);
      end
    end
`ifdef HAZ_PERF_EN
    #4;
    testsRun++;
    if (hz.wait_cnt !== CNT_W'(expWait)) begin
      testsFailed++;
      $display("[TB] FAIL post_reset_wait_cnt: got %0d want %0d", hz.wait_cnt, expWait);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_timeout();
    test_reset_mid_wait();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
